// File: rtl/fp_conv_sched.sv
// Round-robin scheduler that time-shares one combinational fixed-to-float converter
// among NREQ requesters and returns each tagged result through a valid/ready port.
module fp_conv_sched #(
    parameter int NREQ  = 4,
    parameter int ID_W  = 2,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [12*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [11:0]          conv_in,
    input  logic                 conv_sign,
    input  logic [2:0]           conv_exp,
    input  logic [3:0]           conv_sig,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ID_W-1:0]      out_id,
    output logic                 out_sign,
    output logic [2:0]           out_exp,
    output logic [3:0]           out_sig,
    output logic                 busy,
    output logic [CNT_W-1:0]     conv_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [ID_W-1:0]    r_last;
    logic [ID_W-1:0]    r_id;
    logic [11:0]        r_operand;
    logic               r_out_valid;
    logic [ID_W-1:0]    r_out_id;
    logic               r_out_sign;
    logic [2:0]         r_out_exp;
    logic [3:0]         r_out_sig;
    logic               r_busy;
    logic [CNT_W-1:0]   r_count;

    logic               w_found;
    logic [ID_W-1:0]    w_gnt_idx;
    logic [11:0]        w_gnt_data;
    logic [NREQ-1:0]    w_grant;

    // Round-robin scan: the valid requester at the smallest distance after r_last wins.
    always_comb begin : p_scan
        int v_best;
        int v_dist;
        w_found    = 1'b0;
        w_gnt_idx  = '0;
        w_gnt_data = 12'h000;
        v_best     = NREQ;
        v_dist     = 0;
        for (int i = 0; i < NREQ; i++) begin
            v_dist = (i + NREQ - 1 - int'(r_last)) % NREQ;
            if (req_valid[i] && (v_dist < v_best)) begin
                v_best     = v_dist;
                w_found    = 1'b1;
                w_gnt_idx  = ID_W'(i);
                w_gnt_data = req_data[12*i +: 12];
            end else begin
                v_best = v_best;
            end
        end
    end

    // One-hot grant, only offered while idle.
    always_comb begin
        w_grant = '0;
        for (int i = 0; i < NREQ; i++) begin
            if ((r_state == S_IDLE) && w_found && (w_gnt_idx == ID_W'(i))) begin
                w_grant[i] = 1'b1;
            end else begin
                w_grant[i] = 1'b0;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_found) w_next_state = S_CONV;
                else         w_next_state = S_IDLE;
            end
            S_CONV:  w_next_state = S_HOLD;
            S_HOLD: begin
                if (r_out_valid && out_ready) w_next_state = S_IDLE;
                else                          w_next_state = S_HOLD;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // Operand capture, result capture and completion counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last      <= ID_W'(NREQ - 1);
            r_id        <= '0;
            r_operand   <= 12'h000;
            r_out_valid <= 1'b0;
            r_out_id    <= '0;
            r_out_sign  <= 1'b0;
            r_out_exp   <= 3'd0;
            r_out_sig   <= 4'h0;
            r_busy      <= 1'b0;
            r_count     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_operand <= w_gnt_data;
                        r_id      <= w_gnt_idx;
                        r_last    <= w_gnt_idx;
                    end
                end
                S_CONV: begin
                    r_out_sign  <= conv_sign;
                    r_out_exp   <= conv_exp;
                    r_out_sig   <= conv_sig;
                    r_out_id    <= r_id;
                    r_out_valid <= 1'b1;
                end
                S_HOLD: begin
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                        r_count     <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: r_out_valid <= 1'b0;
            endcase
            r_busy <= (w_next_state != S_IDLE);
        end
    end

    assign req_ready  = w_grant;
    assign conv_in    = r_operand;
    assign out_valid  = r_out_valid;
    assign out_id     = r_out_id;
    assign out_sign   = r_out_sign;
    assign out_exp    = r_out_exp;
    assign out_sig    = r_out_sig;
    assign busy       = r_busy;
    assign conv_count = r_count;

endmodule

// File: tb/tb_fp_conv_sched.sv
// Self-checking bench for fp_conv_sched: directed sequences, a vector table and a
// randomized run against a transaction-level round-robin reference model.
module tb_fp_conv_sched;
    localparam int NREQ  = 4;
    localparam int ID_W  = 2;
    localparam int CNT_W = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [12*NREQ-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic [11:0]          conv_in;
    logic                 conv_sign;
    logic [2:0]           conv_exp;
    logic [3:0]           conv_sig;
    logic                 out_valid;
    logic                 out_ready;
    logic [ID_W-1:0]      out_id;
    logic                 out_sign;
    logic [2:0]           out_exp;
    logic [3:0]           out_sig;
    logic                 busy;
    logic [CNT_W-1:0]     conv_count;
    logic [11:0]          data_arr [NREQ];

    // small instance with a 3-bit counter to reach the wrap point quickly
    logic [1:0]   s_req_valid;
    logic [23:0]  s_req_data;
    logic [1:0]   s_req_ready;
    logic [11:0]  s_conv_in;
    logic         s_out_valid;
    logic         s_out_ready;
    logic [0:0]   s_out_id;
    logic         s_out_sign;
    logic [2:0]   s_out_exp;
    logic [3:0]   s_out_sig;
    logic         s_busy;
    logic [2:0]   s_conv_count;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NREQ; i++) req_data[12*i +: 12] = data_arr[i];
    end

    assign conv_sign = conv_in[11];
    assign conv_exp  = conv_in[6:4];
    assign conv_sig  = conv_in[3:0];

    fp_conv_sched #(.NREQ(NREQ), .ID_W(ID_W), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .conv_in(conv_in), .conv_sign(conv_sign),
        .conv_exp(conv_exp), .conv_sig(conv_sig), .out_valid(out_valid),
        .out_ready(out_ready), .out_id(out_id), .out_sign(out_sign),
        .out_exp(out_exp), .out_sig(out_sig), .busy(busy), .conv_count(conv_count)
    );

    fp_conv_sched #(.NREQ(2), .ID_W(1), .CNT_W(3)) u_dut_small (
        .clk(clk), .rst(rst), .req_valid(s_req_valid), .req_data(s_req_data),
        .req_ready(s_req_ready), .conv_in(s_conv_in), .conv_sign(s_conv_in[11]),
        .conv_exp(s_conv_in[6:4]), .conv_sig(s_conv_in[3:0]), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .out_id(s_out_id), .out_sign(s_out_sign),
        .out_exp(s_out_exp), .out_sig(s_out_sig), .busy(s_busy), .conv_count(s_conv_count)
    );

    typedef struct {
        logic [11:0]     data;
        logic [ID_W-1:0] id;
        logic            sign;
        logic [2:0]      exp;
        logic [3:0]      sig;
    } vec_t;

    vec_t tbl [NREQ];
    int   n_checks = 0;
    int   n_fail   = 0;

    // model state for the randomized run
    logic          m_out;
    int            m_age;
    int            m_id;
    logic [7:0]    m_res;
    int            m_last;
    logic [15:0]   m_count;
    logic [3:0]    exp_ready;
    logic          exp_ov;
    int            pick;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [7:0] conv8(input logic [11:0] d);
        return {d[11], d[6:4], d[3:0]};
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (last + k) % NREQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        tbl[0] = '{12'h123, 2'd0, 1'b0, 3'd2, 4'h3};
        tbl[1] = '{12'hFED, 2'd1, 1'b1, 3'd6, 4'hD};
        tbl[2] = '{12'h85A, 2'd2, 1'b1, 3'd5, 4'hA};
        tbl[3] = '{12'h7F0, 2'd3, 1'b0, 3'd7, 4'h0};

        rst = 1'b1; req_valid = '0; out_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) data_arr[i] = 12'h000;
        s_req_valid = 2'b00; s_req_data = 24'h000000; s_out_ready = 1'b1;
        repeat (2) @(posedge clk); #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", conv_count, 0);
        chk("rst_conv_in", conv_in, 0);
        chk("rst_out_id", out_id, 0);
        chk("rst_out_sig", {out_sign, out_exp, out_sig}, 0);
        rst = 1'b0;

        // single request from requester 2
        @(posedge clk); #1;
        data_arr[2] = 12'h8A5; req_valid = 4'b0100; out_ready = 1'b1;
        @(negedge clk);
        chk("t1_ready", req_ready, 4'b0100);
        chk("t1_idle_busy", busy, 0);
        @(posedge clk); #1; req_valid = 4'b0000;
        @(negedge clk);
        chk("t1_conv_busy", busy, 1);
        chk("t1_conv_ready", req_ready, 0);
        chk("t1_conv_ov", out_valid, 0);
        chk("t1_conv_in", conv_in, 12'h8A5);
        @(negedge clk);
        chk("t1_ov", out_valid, 1);
        chk("t1_id", out_id, 2);
        chk("t1_res", {out_sign, out_exp, out_sig}, {1'b1, 3'b010, 4'h5});
        @(negedge clk);
        chk("t1_ov_fall", out_valid, 0);
        chk("t1_count", conv_count, 1);
        chk("t1_busy_fall", busy, 0);
        chk("t1_data_kept", out_sig, 4'h5);

        // backpressure: out_ready low for 5 HOLD cycles, requester 3 waiting
        @(posedge clk); #1;
        data_arr[1] = 12'h3C7; req_valid = 4'b0010; out_ready = 1'b0;
        @(negedge clk);
        chk("t3_ready", req_ready, 4'b0010);
        @(posedge clk); #1;
        data_arr[3] = 12'hA0F; req_valid = 4'b1000;
        @(negedge clk);
        chk("t3_conv_ready", req_ready, 0);
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            chk("t3_hold_ov", out_valid, 1);
            chk("t3_hold_id", out_id, 1);
            chk("t3_hold_res", {out_sign, out_exp, out_sig}, {1'b0, 3'd4, 4'h7});
            chk("t3_hold_ready", req_ready, 0);
            if (j == 4) begin
                @(posedge clk); #1; out_ready = 1'b1;
            end
        end
        @(negedge clk);
        chk("t3_regrant", req_ready, 4'b1000);
        chk("t3_idle_busy", busy, 0);
        chk("t3_count", conv_count, 2);

        // a one-cycle req_valid pulse during HOLD must not produce a grant
        @(posedge clk); #1; req_valid = 4'b0000; out_ready = 1'b0;
        @(negedge clk);
        chk("t6_conv_busy", busy, 1);
        @(posedge clk); #1; req_valid = 4'b0010;
        @(negedge clk);
        chk("t6_hold_ready", req_ready, 0);
        chk("t6_hold_id", out_id, 3);
        @(posedge clk); #1; req_valid = 4'b0000; out_ready = 1'b1;
        @(negedge clk);
        chk("t6_hold_ov", out_valid, 1);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("t6_idle_ready", req_ready, 0);
            chk("t6_idle_busy", busy, 0);
        end
        chk("t6_count", conv_count, 3);

        // asynchronous reset in the middle of CONV
        @(posedge clk); #1; data_arr[0] = 12'h111; req_valid = 4'b0001;
        @(negedge clk);
        chk("t4_ready", req_ready, 4'b0001);
        @(posedge clk); #1;
        data_arr[0] = 12'hB6E; req_valid = 4'b0101;
        #2 rst = 1'b1;
        #1;
        chk("t4_async_ov", out_valid, 0);
        chk("t4_async_busy", busy, 0);
        chk("t4_async_count", conv_count, 0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("t4_prio0", req_ready, 4'b0001);
        chk("t4_no_result", out_valid, 0);
        @(posedge clk); #1; req_valid = 4'b0100;
        @(negedge clk);
        @(negedge clk);
        chk("t4_id", out_id, 0);
        chk("t4_res", {out_sign, out_exp, out_sig}, {1'b1, 3'd6, 4'hE});
        @(negedge clk);
        chk("t4_next", req_ready, 4'b0100);
        chk("t4_count", conv_count, 1);
        @(posedge clk); #1; req_valid = 4'b0000;
        repeat (2) @(posedge clk); #1;

        // vector table: all requesters valid continuously
        pulse_reset();
        for (int i = 0; i < NREQ; i++) data_arr[i] = tbl[i].data;
        req_valid = 4'b1111; out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t2_grant", req_ready, 4'b0001 << (k % NREQ));
            @(negedge clk);
            @(negedge clk);
            chk("t2_ov", out_valid, 1);
            chk("t2_id", out_id, tbl[k % NREQ].id);
            chk("t2_res", {out_sign, out_exp, out_sig},
                {tbl[k % NREQ].sign, tbl[k % NREQ].exp, tbl[k % NREQ].sig});
        end
        @(posedge clk); #1; req_valid = 4'b0000;
        @(negedge clk);
        chk("t2_count", conv_count, 8);

        // randomized run against the reference model
        pulse_reset();
        out_ready = 1'b1;
        m_out = 1'b0; m_age = 0; m_id = 0; m_res = 8'h00; m_last = NREQ - 1; m_count = 16'h0000;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            pick = rr_pick(req_valid, m_last);
            exp_ready = (!m_out && pick >= 0) ? (4'b0001 << pick) : 4'b0000;
            exp_ov = m_out && (m_age >= 2);
            chk("rnd_ready", req_ready, exp_ready);
            chk("rnd_ov", out_valid, exp_ov);
            chk("rnd_busy", busy, m_out);
            chk("rnd_count", conv_count, m_count);
            if (exp_ov) begin
                chk("rnd_id", out_id, m_id);
                chk("rnd_res", {out_sign, out_exp, out_sig}, m_res);
            end
            @(posedge clk);
            if (exp_ready != 4'b0000) begin
                m_out = 1'b1; m_age = 0; m_id = pick; m_res = conv8(data_arr[pick]); m_last = pick;
            end else if (exp_ov && out_ready) begin
                m_out = 1'b0; m_count = m_count + 16'd1;
            end
            if (m_out) m_age++;
            #1;
            if (exp_ready != 4'b0000) req_valid[pick] = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && !(exp_ready[i])) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req_valid[i] = 1'b1;
                        data_arr[i]  = 12'($urandom);
                    end
                end else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 2) != 0);
        end
        req_valid = 4'b0000;

        // counter wrap on the 3-bit instance
        pulse_reset();
        s_req_data = {12'h000, 12'h0F3};
        s_req_valid = 2'b01;
        for (int k = 1; k <= 9; k++) begin
            repeat (3) @(posedge clk);
            @(negedge clk);
            chk("wrap_count", s_conv_count, k % 8);
        end
        s_req_valid = 2'b00;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
